// File: rtl/mem_scan_pkg.sv
// Shared types and default constants for the memory scan sequencer.
package mem_scan_pkg;

    localparam int unsigned ADDR_W_DEF   = 10;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned TICK_DIV_DEF = 50_000_000;
    localparam logic [7:0]  FILL_XOR_DEF = 8'h5A;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_SHOW = 2'd3
    } state_t;

endpackage

// File: rtl/mem_scan_ctrl_if.sv
// RAM port and display path bundle between the scan sequencer and its peripherals.
interface mem_scan_ctrl_if
    import mem_scan_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_di;
    logic [DATA_W-1:0] mem_do;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    modport master (
        output mem_we, mem_addr, mem_di,
        input  mem_do,
        output disp_addr, disp_data, disp_valid
    );

    modport slave (
        input  mem_we, mem_addr, mem_di,
        output mem_do,
        input  disp_addr, disp_data, disp_valid
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV cycles while en is high.
// Cleared whenever en is low, so the first tick lands TICK_DIV cycles after en rises.
module tick_prescaler
    import mem_scan_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Count 0..TICK_DIV-1; tick registered off the terminal count.
    always_ff @(posedge clk) begin
        if (reset || !en) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= (count == LAST) ? '0 : count + 1'b1;
            tick  <= (count == LAST);
        end
    end

endmodule

// File: rtl/mem_scan_ctrl.sv
// Memory scan sequencer: fills the RAM with addr ^ FILL_XOR after reset, then
// reads one address per advance (step pulse or prescaler tick) for display.
// Build option: define MEM_SCAN_VERIFY_EN to check each read byte against the
// fill pattern and raise a sticky err; otherwise err is held at 0.
module mem_scan_ctrl
    import mem_scan_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       TICK_DIV = TICK_DIV_DEF,
    parameter logic [DATA_W-1:0] FILL_XOR = DATA_W'(FILL_XOR_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            step,
    mem_scan_ctrl_if.master bus,
    output logic            busy,
    output logic            err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_di_n;
    logic [ADDR_W-1:0] disp_addr_n;
    logic [DATA_W-1:0] disp_data_n;
    logic              disp_valid_n;
    logic              busy_n;
    logic              err_n;
    logic              tick;
    logic              presc_en_c;
    logic              advance_c;

    // Dwell timer only runs while a byte is on display, giving each byte a full period.
    assign presc_en_c = run && (state == S_SHOW);
    assign advance_c  = (state == S_SHOW) && (step || (run && tick));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en_c),
        .tick  (tick)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        addr_n       = addr;
        mem_we_n     = 1'b0;
        mem_addr_n   = bus.mem_addr;
        mem_di_n     = bus.mem_di;
        disp_addr_n  = bus.disp_addr;
        disp_data_n  = bus.disp_data;
        disp_valid_n = bus.disp_valid;
        busy_n       = busy;
`ifdef MEM_SCAN_VERIFY_EN
        err_n        = err;
`else
        err_n        = 1'b0;
`endif
        case (state)
            S_FILL: begin
                busy_n = 1'b1;
                if (!cnt[ADDR_W]) begin
                    mem_we_n   = 1'b1;
                    mem_addr_n = cnt[ADDR_W-1:0];
                    mem_di_n   = DATA_W'(cnt[ADDR_W-1:0]) ^ FILL_XOR;
                    cnt_n      = cnt + 1'b1;
                end else begin
                    mem_addr_n = '0;
                    addr_n     = '0;
                    state_n    = S_READ;
                end
            end
            S_READ: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // RAM output is valid now; capture on the edge into SHOW.
                disp_data_n  = bus.mem_do;
                disp_addr_n  = addr;
                disp_valid_n = 1'b1;
                busy_n       = 1'b0;
`ifdef MEM_SCAN_VERIFY_EN
                if (bus.mem_do != (DATA_W'(addr) ^ FILL_XOR)) begin
                    err_n = 1'b1;
                end
`endif
                state_n = S_SHOW;
            end
            S_SHOW: begin
                if (advance_c) begin
                    addr_n     = addr + 1'b1;
                    mem_addr_n = addr + 1'b1;
                    busy_n     = 1'b1;
                    state_n    = S_READ;
                end
            end
            default: begin
                state_n = S_FILL;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_FILL;
            cnt            <= '0;
            addr           <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_di     <= '0;
            bus.disp_addr  <= '0;
            bus.disp_data  <= '0;
            bus.disp_valid <= 1'b0;
            busy           <= 1'b1;
            err            <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            addr           <= addr_n;
            bus.mem_we     <= mem_we_n;
            bus.mem_addr   <= mem_addr_n;
            bus.mem_di     <= mem_di_n;
            bus.disp_addr  <= disp_addr_n;
            bus.disp_data  <= disp_data_n;
            bus.disp_valid <= disp_valid_n;
            busy           <= busy_n;
            err            <= err_n;
        end
    end

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Scoreboard bench for mem_scan_ctrl (ADDR_W=3, TICK_DIV=4, FILL_XOR=5A).
module tb_mem_scan_ctrl;

`ifdef MEM_SCAN_VERIFY_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic step = 1'b0;
    logic busy;
    logic err;
    logic corrupt = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int show_cnt = 0;
    int show_cyc = 0;
    int show_cyc_prev = 0;
    logic prev_busy = 1'b1;

    typedef struct {
        int addr;
        int data;
        int err;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mem [8];
    logic [7:0] fill_tab [8] = '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F, 8'h5C, 8'h5D};

    mem_scan_ctrl_if #(.ADDR_W(3), .DATA_W(8)) bus ();

    mem_scan_ctrl #(
        .ADDR_W   (3),
        .DATA_W   (8),
        .TICK_DIV (4),
        .FILL_XOR (8'h5A)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .step  (step),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 1-cycle-latency RAM; corrupt zaps address 3.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_di;
        if (corrupt) mem[3] <= 8'h00;
        bus.mem_do <= mem[bus.mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int a, input int d, input int e);
        exp_t x;
        x.addr = a;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Monitor: every new display capture shows up as busy falling.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && prev_busy && !busy) begin
            show_cnt++;
            show_cyc_prev = show_cyc;
            show_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_show: got addr %0d data %0h, expected no update", bus.disp_addr, bus.disp_data);
            end else begin
                e = sb.pop_front();
                chk("disp_addr", int'(bus.disp_addr), e.addr);
                chk("disp_data", int'(bus.disp_data), e.data);
                chk("disp_valid", int'(bus.disp_valid), 1);
                chk("err", int'(err), e.err);
            end
        end
        prev_busy = busy;
    end

    task automatic wait_show(input int budget);
        int start;
        int seen;
        start = show_cnt;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (show_cnt != start) begin
                seen = 1;
                break;
            end
        end
        chk("show_seen", seen, 1);
    endtask

    task automatic fill_count();
        int start;
        int n;
        int ok;
        int seen;
        start = show_cnt;
        n = 0;
        ok = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (bus.mem_we) begin
                if (int'(bus.mem_addr) != n) ok = 0;
                n++;
            end
            if (show_cnt != start) begin
                seen = 1;
                break;
            end
        end
        chk("fill_len", n, 8);
        chk("fill_order", ok, 1);
        chk("fill_show_seen", seen, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_mem_we", int'(bus.mem_we), 0);
        chk("rst_mem_addr", int'(bus.mem_addr), 0);
        chk("rst_mem_di", int'(bus.mem_di), 0);
        chk("rst_disp_addr", int'(bus.disp_addr), 0);
        chk("rst_disp_data", int'(bus.disp_data), 0);
        chk("rst_disp_valid", int'(bus.disp_valid), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_err", int'(err), 0);
    endtask

    task automatic cyc_start();
        @(posedge clk); #1;
    endtask

    initial begin
        int hit;

        // 1: reset, fill, first display of address 0
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        push(0, 'h5A, 0);
        reset = 1'b0;
        fill_count();
        for (int i = 0; i < 8; i++) chk("mem_fill", int'(mem[i]), int'(fill_tab[i]));
        chk("busy_after_fill", int'(busy), 0);

        // 2: single step, 3-cycle visibility latency, no drift afterwards
        push(1, 'h5B, 0);
        cyc_start(); step = 1'b1;
        cyc_start(); step = 1'b0;
        @(negedge clk); chk("step_lat_n1", int'(bus.disp_addr), 0);
        @(negedge clk); chk("step_lat_n2", int'(bus.disp_addr), 0);
        chk("step_busy_n2", int'(busy), 1);
        @(negedge clk); chk("step_lat_n3", int'(bus.disp_addr), 1);
        repeat (10) @(negedge clk);
        chk("step_hold", int'(bus.disp_addr), 1);

        // 3: auto-advance with wrap, 7-cycle period
        push(2, 'h58, 0); push(3, 'h59, 0); push(4, 'h5E, 0); push(5, 'h5F, 0);
        push(6, 'h5C, 0); push(7, 'h5D, 0); push(0, 'h5A, 0); push(1, 'h5B, 0);
        cyc_start(); run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_show(20);
            if (k > 0) chk("run_period", show_cyc - show_cyc_prev, 7);
        end
        cyc_start(); run = 1'b0;

        // 4: step coincident with tick, plus a step during WAIT
        push(2, 'h58, 0);
        cyc_start(); run = 1'b1;
        repeat (4) cyc_start();
        step = 1'b1;
        cyc_start(); step = 1'b0; run = 1'b0;
        cyc_start(); step = 1'b1;
        cyc_start(); step = 1'b0;
        @(negedge clk); chk("coincident_addr", int'(bus.disp_addr), 2);
        repeat (12) @(negedge clk);
        chk("wait_step_ignored", int'(bus.disp_addr), 2);

        // 5: reset mid-fill at cnt = 4
        cyc_start(); reset = 1'b1;
        cyc_start(); reset = 1'b0;
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_we && bus.mem_addr == 3'd3) begin
                hit = 1;
                break;
            end
        end
        chk("mid_fill_seen", hit, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        push(0, 'h5A, 0);
        reset = 1'b0;
        fill_count();

        // 6: corrupt address 3, scan through the wrap
        cyc_start(); corrupt = 1'b1;
        cyc_start(); corrupt = 1'b0;
        push(1, 'h5B, 0); push(2, 'h58, 0); push(3, 'h00, V); push(4, 'h5E, V);
        push(5, 'h5F, V); push(6, 'h5C, V); push(7, 'h5D, V); push(0, 'h5A, V);
        push(1, 'h5B, V);
        run = 1'b1;
        for (int k = 0; k < 9; k++) wait_show(20);
        cyc_start(); run = 1'b0;
        repeat (10) @(negedge clk);
        chk("err_final", int'(err), V);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_scan_ctrl.md
Name: mem_scan_ctrl

Overview:
- Sequencer between the 1K x 8 synchronous block RAM and the hex_to_sseg / disp_mux display path.
- After reset it fills the RAM with a known pattern. It then steps through addresses one at a time, either automatically at a slow tick or on a single-step pulse.
- Each read byte is presented, together with its address, to the display logic.
- It replaces the constant write-enable/address/data ties currently driving the memory.

Parameters:
- ADDR_W, 10, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- TICK_DIV, 50_000_000, clk cycles per auto-advance tick (1 s at 50 MHz); minimum 2.
- FILL_XOR, 8'h5A, pattern constant; fill value for address a is a[DATA_W-1:0] ^ FILL_XOR.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  level; 1 = auto-advance on each prescaler tick.
- step  in  1  single-cycle pulse; advance one address.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_di  out  DATA_W  RAM write data.
- mem_do  in  DATA_W  RAM read data; registered, valid 1 cycle after the address is sampled.
- disp_addr  out  ADDR_W  address of the currently displayed byte.
- disp_data  out  DATA_W  byte to display (feeds hex_to_sseg nibbles).
- disp_valid  out  1  1 once the first read has been captured.
- busy  out  1  1 during FILL and during READ/WAIT.
- err  out  1  sticky verify mismatch (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - FSM = FILL, fill counter = 0, prescaler = 0.
  - mem_we = 0, mem_addr = 0, mem_di = 0.
  - disp_addr = 0, disp_data = 0, disp_valid = 0, busy = 1, err = 0.
- All outputs are registered.
- FSM states: FILL -> READ -> WAIT -> SHOW -> (advance) READ ...
- FILL:
  - One write per cycle: mem_we = 1, mem_addr = cnt, mem_di = cnt[DATA_W-1:0] ^ FILL_XOR.
  - cnt runs 0..2**ADDR_W-1.
  - After the last address: mem_we = 0, next address = 0, go to READ.
  - Duration is exactly 2**ADDR_W cycles with mem_we = 1.
- READ: mem_we = 0; mem_addr = next address; go to WAIT.
- WAIT: RAM latency cycle; go to SHOW.
- SHOW entry:
  - disp_data <= mem_do, disp_addr <= address just read, disp_valid <= 1, busy <= 0.
  - Hold until an advance event.
- Advance event:
  - In SHOW only: step == 1, or (run == 1 and prescaler tick).
  - A simultaneous step and tick cause a single advance.
  - step or tick outside SHOW is ignored, not queued.
  - Latency: advance event in cycle N -> disp_data/disp_addr update at the end of cycle N+2.
- Address wrap: the address after 2**ADDR_W-1 is 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run = 1; tick is asserted when count == TICK_DIV-1.
  - Clears to 0 when run = 0, giving a deterministic first tick TICK_DIV cycles after run rises.
- Reset at any point (mid-FILL, READ, WAIT, SHOW):
  - Returns to the reset values above.
  - The fill restarts from address 0.
- Widths: the fill counter is ADDR_W+1 bits internally to detect completion; the address counter is ADDR_W bits and wraps naturally.

Optional Feature:
- Macro: MEM_SCAN_VERIFY_EN.
- Defined:
  - On SHOW entry, compare mem_do against disp_addr_next[DATA_W-1:0] ^ FILL_XOR.
  - A mismatch sets err = 1; err stays set until reset.
  - disp_data still shows the actual read byte.
- Not defined: no comparator is instantiated; err is tied to 0. The port list is identical in both builds.

Decomposition:
- Package mem_scan_pkg holds:
  - FSM state encoding (S_FILL, S_READ, S_WAIT, S_SHOW).
  - Default ADDR_W, DATA_W, FILL_XOR constants.
- One sub-module: tick_prescaler (parameter TICK_DIV; ports clk, reset, en, tick), reusable by disp_mux refresh logic.
- The FSM and datapath stay in mem_scan_ctrl.

Test Plan:
All scenarios use ADDR_W = 3, TICK_DIV = 4, FILL_XOR = 8'h5A with a behavioural 1-cycle-latency RAM model.
1. Reset then idle -> mem_we = 1 for exactly 8 cycles; mem[0..7] = 5A,5B,58,59,5E,5F,5C,5D; then disp_addr = 0, disp_data = 5A, disp_valid = 1, busy = 0.
2. run = 0, step pulse in SHOW at cycle N -> disp_addr = 1, disp_data = 5B, visible at N+3; no further change without another pulse.
3. run = 1 held -> disp_addr advances every 4+3 cycles; after address 7 (5D) it wraps to address 0 (5A).
4. step asserted in the same cycle as a tick, and step asserted during WAIT -> one advance only; the WAIT pulse is ignored.
5. reset asserted mid-FILL at cnt = 4 -> all outputs return to reset values next cycle; the fill restarts at address 0 with 8 full writes.
6. With MEM_SCAN_VERIFY_EN, RAM model corrupts mem[3] to 00 after fill -> err rises when address 3 is shown and stays 1 through the wrap; without the macro, err stays 0.
